des_sequence_controller: RTL and testbench

//  Top-level sequencer for the I2C Triple-DES core. Loads NUM_KEYS keys, then runs a burst
//  of up to MAX_BLOCKS encrypt/decrypt blocks per I2C transaction. Adds a DES-engine watchdog,

---
 rtl/des_ctrl_pkg.sv | 20 ++
 rtl/des_watchdog_timer.sv | 29 ++
 rtl/des_sequence_controller.sv | 149 ++++++++++++++
 tb/tb_des_sequence_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/des_ctrl_pkg.sv
// Shared types for the Triple-DES sequence controller: FSM state encoding and mode constants.
package des_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        KEY_LOAD,
        KEY_WAIT,
        MODE_SEL,
        WAIT_DATA,
        START,
        RUN,
        XFER,
        DONE,
        ERR
    } des_seq_state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/des_watchdog_timer.sv
// DES-engine watchdog: counts enabled cycles since clear and flags the cycle on which
// the LIMIT-1'th consecutive wait would be reached.
module des_watchdog_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    // Incremented value hitting LIMIT-1 means ERR is entered LIMIT cycles after START.
    assign expired = enable && (count == CW'(LIMIT - 2));

endmodule

// File: rtl/des_sequence_controller.sv
// Sequencer for the I2C Triple-DES core: key loading, per-block DES handshake with
// watchdog, burst limit, and abort on I2C stop.
module des_sequence_controller
    import des_ctrl_pkg::*;
#(
    parameter int NUM_KEYS       = 3,
    parameter int MAX_BLOCKS     = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int BLK_W          = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                i2c_stop,
    input  logic                i2c_rw,
    input  logic                data_ready,
    input  logic                next_data,
    output logic [NUM_KEYS-1:0] key_load,
    output logic                des_ready,
    output logic                dir_io_sel,
    output logic                ag_enable,
    output logic                output_load_enable,
    output logic                output_ready,
    output logic [BLK_W-1:0]    block_count,
    output logic                busy,
    output logic                error
);

    localparam int KI_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    des_seq_state_t    state, state_nxt;
    logic [KI_W-1:0]   k_idx, k_nxt;
    logic              mode, mode_nxt;
    logic [BLK_W-1:0]  bc_nxt;
    logic              wd_clear, wd_en, wd_expired;
    logic              abort;

    des_watchdog_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            k_idx       <= '0;
            mode        <= MODE_ENC;
            block_count <= '0;
        end else begin
            state       <= state_nxt;
            k_idx       <= k_nxt;
            mode        <= mode_nxt;
            block_count <= bc_nxt;
        end
    end

    assign abort = i2c_stop && !(state inside {IDLE, DONE, ERR});

    always_comb begin
        state_nxt          = state;
        k_nxt              = k_idx;
        mode_nxt           = mode;
        bc_nxt             = block_count;
        wd_clear           = 1'b0;
        wd_en              = 1'b0;
        key_load           = '0;
        des_ready          = 1'b0;
        dir_io_sel         = 1'b0;
        ag_enable          = 1'b0;
        output_load_enable = 1'b0;
        output_ready       = 1'b0;
        busy               = (state != IDLE);
        error              = 1'b0;

        case (state)
            IDLE: begin
                if (data_ready) begin
                    state_nxt = KEY_LOAD;
                    k_nxt     = '0;
                    bc_nxt    = '0;
                end
            end
            KEY_LOAD: begin
                key_load = NUM_KEYS'(1) << k_idx;
                if (k_idx == KI_W'(NUM_KEYS - 1)) begin
                    state_nxt = MODE_SEL;
                end else begin
                    k_nxt     = k_idx + 1'b1;
                    state_nxt = KEY_WAIT;
                end
            end
            KEY_WAIT: if (data_ready) state_nxt = KEY_LOAD;
            MODE_SEL: begin
                // Direction is taken live from i2c_rw here so a read can prefetch its address.
                mode_nxt   = i2c_rw;
                dir_io_sel = i2c_rw;
                ag_enable  = (i2c_rw == MODE_DEC);
                state_nxt  = WAIT_DATA;
            end
            WAIT_DATA: begin
                dir_io_sel = mode;
                if (data_ready) state_nxt = START;
            end
            START: begin
                dir_io_sel = mode;
                des_ready  = 1'b1;
                wd_clear   = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                dir_io_sel = mode;
                wd_en      = 1'b1;
                if (next_data)       state_nxt = XFER;
                else if (wd_expired) state_nxt = ERR;
            end
            XFER: begin
                dir_io_sel         = mode;
                output_load_enable = 1'b1;
                output_ready       = mode;
                ag_enable          = (mode == MODE_ENC);
                bc_nxt             = block_count + 1'b1;
                state_nxt          = DONE;
            end
            DONE: begin
                dir_io_sel         = mode;
                output_load_enable = 1'b1;
                output_ready       = mode;
                if (i2c_stop || block_count == BLK_W'(MAX_BLOCKS)) state_nxt = IDLE;
                else                                                state_nxt = WAIT_DATA;
            end
            ERR: begin
                error = 1'b1;
                if (i2c_stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Stop overrides every other transition and leaves the counters untouched.
        if (abort) begin
            state_nxt = IDLE;
            k_nxt     = k_idx;
            mode_nxt  = mode;
            bc_nxt    = block_count;
        end
    end

endmodule

// File: tb/tb_des_sequence_controller.sv
// Bench for des_sequence_controller: directed scenarios plus random traffic against a
// transaction-level model, on a default instance and a small (1 key, 2 blocks) instance.
module tb_des_sequence_controller;

    localparam int NK1 = 3, MB1 = 16, TO1 = 64;
    localparam int NK2 = 1, MB2 = 2,  TO2 = 4;

    localparam int P_IDLE = 0, P_KL = 1, P_KW = 2, P_MS = 3, P_WD = 4,
                   P_ST = 5, P_RUN = 6, P_XF = 7, P_DN = 8, P_ERR = 9;

    typedef struct packed {
        int ph;
        int k;
        bit mode;
        int tmr;
        int bc;
    } mdl_t;

    logic clk, n_rst, i2c_stop, i2c_rw, data_ready, next_data;

    logic [NK1-1:0] kl1;
    logic [4:0]     bc1;
    logic           dsr1, dir1, ag1, ole1, ordy1, busy1, err1;
    logic [NK2-1:0] kl2;
    logic [1:0]     bc2;
    logic           dsr2, dir2, ag2, ole2, ordy2, busy2, err2;

    logic [15:0] act1, act2;
    assign act1 = {4'(kl1), dsr1, dir1, ag1, ole1, ordy1, busy1, err1, 5'(bc1)};
    assign act2 = {4'(kl2), dsr2, dir2, ag2, ole2, ordy2, busy2, err2, 5'(bc2)};

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 0;
    mdl_t m1, m2;

    des_sequence_controller #(.NUM_KEYS(NK1), .MAX_BLOCKS(MB1), .TIMEOUT_CYCLES(TO1)) dut (
        .clk(clk), .n_rst(n_rst), .i2c_stop(i2c_stop), .i2c_rw(i2c_rw),
        .data_ready(data_ready), .next_data(next_data),
        .key_load(kl1), .des_ready(dsr1), .dir_io_sel(dir1), .ag_enable(ag1),
        .output_load_enable(ole1), .output_ready(ordy1), .block_count(bc1),
        .busy(busy1), .error(err1)
    );

    des_sequence_controller #(.NUM_KEYS(NK2), .MAX_BLOCKS(MB2), .TIMEOUT_CYCLES(TO2)) dut_small (
        .clk(clk), .n_rst(n_rst), .i2c_stop(i2c_stop), .i2c_rw(i2c_rw),
        .data_ready(data_ready), .next_data(next_data),
        .key_load(kl2), .des_ready(dsr2), .dir_io_sel(dir2), .ag_enable(ag2),
        .output_load_enable(ole2), .output_ready(ordy2), .block_count(bc2),
        .busy(busy2), .error(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mreset();
        mdl_t q;
        q.ph = P_IDLE; q.k = 0; q.mode = 1'b0; q.tmr = 0; q.bc = 0;
        return q;
    endfunction

    // Transaction rules: what happens to the sequence on one clock given the inputs.
    function automatic mdl_t mstep(mdl_t m, int nk, int mb, int to, bit d, bit n, bit s, bit r);
        mdl_t q;
        q = m;
        if (s && !(m.ph inside {P_IDLE, P_DN, P_ERR})) begin
            q.ph = P_IDLE;
            return q;
        end
        case (m.ph)
            P_IDLE: if (d) begin q.ph = P_KL; q.k = 0; q.bc = 0; end
            P_KL:   if (m.k == nk - 1) q.ph = P_MS;
                    else begin q.k = m.k + 1; q.ph = P_KW; end
            P_KW:   if (d) q.ph = P_KL;
            P_MS:   begin q.mode = r; q.ph = P_WD; end
            P_WD:   if (d) q.ph = P_ST;
            P_ST:   begin q.tmr = 0; q.ph = P_RUN; end
            P_RUN:  if (n) q.ph = P_XF;
                    else begin q.tmr = m.tmr + 1; if (q.tmr == to - 1) q.ph = P_ERR; end
            P_XF:   begin q.bc = m.bc + 1; q.ph = P_DN; end
            P_DN:   q.ph = (s || m.bc == mb) ? P_IDLE : P_WD;
            P_ERR:  if (s) q.ph = P_IDLE;
            default: ;
        endcase
        return q;
    endfunction

    function automatic logic [15:0] mexp(mdl_t m, bit r);
        logic [3:0] kl;
        logic dir, ag, ole;
        kl  = (m.ph == P_KL) ? 4'(1 << m.k) : 4'd0;
        dir = (m.ph == P_MS) ? r : ((m.ph inside {P_WD, P_ST, P_RUN, P_XF, P_DN}) ? m.mode : 1'b0);
        ag  = (m.ph == P_MS && r) || (m.ph == P_XF && !m.mode);
        ole = (m.ph inside {P_XF, P_DN});
        return {kl, (m.ph == P_ST), dir, ag, ole, ole && m.mode,
                (m.ph != P_IDLE), (m.ph == P_ERR), 5'(m.bc)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m1 <= mreset();
            m2 <= mreset();
        end else begin
            m1 <= mstep(m1, NK1, MB1, TO1, data_ready, next_data, i2c_stop, i2c_rw);
            m2 <= mstep(m2, NK2, MB2, TO2, data_ready, next_data, i2c_stop, i2c_rw);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_dut", act1, mexp(m1, i2c_rw));
            chk("model_dut_small", act2, mexp(m2, i2c_rw));
        end
    end

    // Drive inputs for one cycle, return just after the edge that consumed them.
    task automatic cyc(input bit d, input bit n, input bit s, input bit r);
        data_ready = d; next_data = n; i2c_stop = s; i2c_rw = r;
        @(posedge clk);
        #1;
        data_ready = 1'b0; next_data = 1'b0; i2c_stop = 1'b0;
    endtask

    // Three-key load on the default instance, ending in MODE_SEL.
    task automatic load3(input bit r);
        cyc(1, 0, 0, r); cyc(0, 0, 0, r);
        cyc(1, 0, 0, r); cyc(0, 0, 0, r);
        cyc(1, 0, 0, r); cyc(0, 0, 0, r);
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    initial begin
        int n;
        bit hold;
        n_rst = 1'b0; i2c_stop = 0; i2c_rw = 0; data_ready = 0; next_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dut", act1, 0);
        chk("reset_dut_small", act2, 0);
        n_rst = 1'b1;
        cmp_en = 1'b1;

        // Encrypt, one block
        cyc(1, 0, 0, 0); chk("t1_key0", kl1, 3'b001); chk("t1_busy", busy1, 1);
        cyc(0, 0, 0, 0); chk("t1_keywait", kl1, 3'b000);
        cyc(1, 0, 0, 0); chk("t1_key1", kl1, 3'b010);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0); chk("t1_key2", kl1, 3'b100);
        cyc(0, 0, 0, 0); chk("t1_modesel_ag", ag1, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0); chk("t1_des_ready", dsr1, 1);
        cyc(0, 0, 0, 0); chk("t1_des_ready_1cyc", dsr1, 0);
        repeat (9) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("t1_xfer_strobes", {ole1, ag1, ordy1, dir1}, 4'b1100);
        chk("t1_xfer_count", bc1, 0);
        cyc(0, 0, 0, 0);
        chk("t1_done_strobes", {ole1, ag1, ordy1}, 3'b100);
        chk("t1_done_count", bc1, 1);
        chk("t1_model_count", m1.bc, 1);
        cyc(0, 0, 1, 0); chk("t1_stop_idle", busy1, 0); chk("t1_count_hold", bc1, 1);

        // Decrypt burst of four, stop in DONE
        load3(1);
        chk("t2_prefetch_ag", ag1, 1); chk("t2_dir", dir1, 1);
        cyc(0, 0, 0, 1);
        for (int b = 1; b <= 4; b++) begin
            cyc(1, 0, 0, 1); cyc(0, 0, 0, 1);
            repeat (3) cyc(0, 0, 0, 1);
            cyc(0, 1, 0, 1);
            chk("t2_xfer", {ole1, ordy1, ag1}, 3'b110);
            cyc(0, 0, 0, 1);
            chk("t2_done", {ole1, ordy1}, 2'b11);
            chk("t2_count", bc1, b);
            cyc(0, 0, (b == 4), 1);
        end
        chk("t2_idle", busy1, 0); chk("t2_final_count", bc1, 4);

        // Watchdog
        load3(0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
        n = 0;
        do begin
            cyc(0, 0, 0, 0);
            n++;
        end while (!err1 && n < 200);
        chk("t3_err_latency", n, 64);
        repeat (5) cyc(0, 0, 0, 0);
        chk("t3_err_sticky", {err1, busy1}, 2'b11);
        cyc(0, 0, 1, 0); chk("t3_err_cleared", {err1, busy1}, 2'b00);
        cyc(1, 0, 0, 0); chk("t3_next_txn", {err1, kl1}, 4'b0001);

        // Abort in KEY_WAIT, then in RUN
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0); chk("t5_kw_abort", {busy1, kl1}, 4'b0000);
        cyc(0, 0, 0, 0); chk("t5_kw_quiet", {busy1, kl1}, 4'b0000);
        load3(0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0); chk("t5_run_abort", {busy1, ole1}, 2'b00);
        cyc(0, 1, 0, 0); chk("t5_run_quiet", {busy1, ole1}, 2'b00);

        // Asynchronous reset mid-RUN
        load3(0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        #2 n_rst = 1'b0;
        #1 chk("t6_async_dut", act1, 0); chk("t6_async_dut_small", act2, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        cyc(0, 0, 0, 0); chk("t6_idle_after", act1, 0);

        // Burst limit on the small instance (1 key, 2 blocks)
        cyc(1, 0, 0, 0); chk("t4_key0", kl2, 1'b1);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        for (int b = 1; b <= 2; b++) begin
            cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0); chk("t4_count", bc2, b);
            cyc(0, 0, 0, 0);
        end
        chk("t4_idle", busy2, 0); chk("t4_count_hold", bc2, 2);
        chk("t4_model_count", m2.bc, 2);
        cyc(1, 0, 0, 0); chk("t4_restart", {busy2, kl2, bc2}, 4'b1100);

        // Random traffic; stop only where no strobe would be cut short.
        pulse_reset();
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            bit d, nd, s, allow;
            if ($urandom_range(0, 99) == 0) hold = !hold;
            d  = ($urandom_range(0, 3) == 0);
            nd = !hold && ($urandom_range(0, 5) == 0);
            allow = !(m1.ph inside {P_KL, P_MS, P_ST, P_XF}) && !(m2.ph inside {P_KL, P_MS, P_ST, P_XF});
            s  = allow && ($urandom_range(0, 15) == 0);
            cyc(d, nd, s, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
